// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
//   Memory-stage load/store unit of the 5-stage pipeline. Sits between the
//   EX/MEM and MEM/WB registers, drives a valid/ready data-memory port,
//   returns sign/zero-extended load data and stalls the pipeline while an
//   access is outstanding. A watchdog aborts accesses that never complete.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent in BUSY waiting for dmem_ready (>=1)
//
// Optional build macro
//   MISALIGN_TRAP_EN  misaligned H/HU/W accesses issue no request and
//                     complete in one stall cycle with BusErrM=1.
//                     Undefined: low address bits below the size are ignored.
//
// Ports
//   clk, rst_n        clock (posedge), asynchronous active-low reset
//   MemReadM          load in M stage
//   MemWriteM         store in M stage
//   Funct3M[2:0]      000 B, 001 H, 010 W, 100 BU, 101 HU (others: word)
//   ALUResultM[31:0]  byte address
//   WriteDataM[31:0]  store data, LSB-aligned
//   dmem_req          request valid
//   dmem_we           1 = write
//   dmem_addr[31:0]   word-aligned address
//   dmem_wdata[31:0]  store data replicated across byte lanes
//   dmem_wstrb[3:0]   byte enables (0 on reads)
//   dmem_ready        memory accepts/completes the request this cycle
//   dmem_rdata[31:0]  read word
//   ReadData[31:0]    extended load result to MEM/WB
//   StallM            freeze upstream stages; MEM/WB must not capture
//   BusErrM           access aborted (timeout or misalignment trap)
// ----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          acc;
    logic          is_unsigned;
    logic [1:0]    lane;
    logic          misalign;
    logic          req;
    logic          stall;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_val;
    logic [31:0]   capture_val;

    assign acc         = MemReadM | MemWriteM;
    assign is_unsigned = Funct3M[2];
    assign lane        = ALUResultM[1:0];

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        unique case (Funct3M[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ALUResultM[0];
            default: misalign = |ALUResultM[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Request fields follow the M-stage inputs directly; StallM keeps them stable.
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALUResultM[31:2], 2'b00};

    always_comb begin
        dmem_wstrb = '0;
        dmem_wdata = WriteDataM;
        unique case (Funct3M[1:0])
            2'b00: begin
                dmem_wdata = {4{WriteDataM[7:0]}};
                if (MemWriteM) dmem_wstrb = 4'b0001 << lane;
            end
            2'b01: begin
                dmem_wdata = {2{WriteDataM[15:0]}};
                if (MemWriteM) dmem_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                if (MemWriteM) dmem_wstrb = 4'b1111;
            end
        endcase
    end

    // Lane extraction and extension of the returned word.
    always_comb begin
        sel_byte = dmem_rdata[{lane, 3'b000} +: 8];
        sel_half = dmem_rdata[{ALUResultM[1], 4'b0000} +: 16];
        unique case (Funct3M[1:0])
            2'b00:   load_val = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            default: load_val = dmem_rdata;
        endcase
        capture_val = MemWriteM ? '0 : load_val;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        req     = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (acc) begin
                    stall = 1'b1;
                    if (misalign) begin
                        state_d = DONE;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (dmem_ready) begin
                            state_d = DONE;
                            rdata_d = capture_val;
                            err_d   = 1'b0;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                req   = 1'b1;
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (dmem_ready) begin
                    state_d = DONE;
                    rdata_d = capture_val;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Gated with rst_n so the request and stall drop as soon as reset asserts,
    // even while the M-stage inputs still show an access.
    assign dmem_req = req & rst_n;
    assign StallM   = stall & rst_n;
    assign ReadData = rdata_q;
    assign BusErrM  = err_q;

endmodule
